// File: rtl/ledg_pwm_fader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ledg_pwm_fader_if : LED word in, PWM drive and busy flag out      |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface ledg_pwm_fader_if #(
    parameter int N = 9
);
    logic [N-1:0] led_in;
    logic         fade_en;
    logic [N-1:0] led_out;
    logic         busy;

    modport master (
        output led_in,
        output fade_en,
        input  led_out,
        input  busy
    );

    modport slave (
        input  led_in,
        input  fade_en,
        output led_out,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/ledg_pwm_fader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ledg_pwm_fader : per-channel linear PWM fade of the LEDG PIO word |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module ledg_pwm_fader #(
    parameter int N           = 9,
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 1024
) (
    input  wire               clk,
    input  wire               reset_n,
    ledg_pwm_fader_if.slave   bus
);
    localparam int                   c_step_w    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0]  c_max       = '1;
    localparam logic [c_step_w-1:0]  c_step_last = c_step_w'(STEP_CYCLES - 1);
    localparam logic [c_step_w-1:0]  c_step_one  = c_step_w'(1);
    localparam logic [PWM_BITS-1:0]  c_pwm_one   = PWM_BITS'(1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [c_step_w-1:0] presc_q,   presc_d;
    logic [N-1:0]        led_out_q, led_out_d;
    logic                busy_q,    busy_d;

    logic                w_step_tick;
    logic [N-1:0]        w_led_next;
    logic [N-1:0]        w_mismatch;

    assign w_step_tick = (presc_q == c_step_last);

    // Each channel owns its brightness level and output compare.
    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [PWM_BITS-1:0] level_q, level_d;
        logic [PWM_BITS-1:0] w_target;
        logic                w_led;

        always_comb begin
            w_target = bus.led_in[i] ? c_max : '0;
            level_d  = level_q;
            w_led    = 1'b0;
            if (!bus.fade_en) begin
                // Bypass snaps the level to its endpoint so re-enabling fade cannot ramp.
                level_d = w_target;
                w_led   = bus.led_in[i];
            end else begin
                if (w_step_tick) begin
                    if (bus.led_in[i] && (level_q != c_max)) begin
                        level_d = level_q + c_pwm_one;
                    end else if (!bus.led_in[i] && (level_q != '0)) begin
                        level_d = level_q - c_pwm_one;
                    end
                end
                if (level_q == c_max) begin
                    w_led = 1'b1;
                end else begin
                    w_led = (level_q > pwm_cnt_q);
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                level_q <= '0;
            end else begin
                level_q <= level_d;
            end
        end

        assign w_led_next[i] = w_led;
        assign w_mismatch[i] = (level_q != w_target);
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + c_pwm_one;
        presc_d   = w_step_tick ? '0 : (presc_q + c_step_one);
        led_out_d = w_led_next;
        busy_d    = |w_mismatch;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            presc_q   <= '0;
            led_out_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            presc_q   <= presc_d;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.led_out = led_out_q;
    assign bus.busy    = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_ledg_pwm_fader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ledg_pwm_fader : directed stimulus, cycle model and literals   |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_ledg_pwm_fader;
    localparam int N    = 9;
    localparam int PB   = 4;
    localparam int STEP = 2;
    localparam int MAXV = (1 << PB) - 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int total = 0;
    int bad   = 0;

    ledg_pwm_fader_if #(.N(N)) bus ();

    ledg_pwm_fader #(.N(N), .PWM_BITS(PB), .STEP_CYCLES(STEP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model: brightness per channel, time measured in cycles since reset release.
    int           lvl [N];
    int           cyc      = 0;
    logic [N-1:0] exp_led  = '0;
    logic         exp_busy = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) lvl[i] = 0;
            cyc      = 0;
            exp_led  = '0;
            exp_busy = 1'b0;
        end else begin
            int  pwm;
            int  tgt;
            bit  tick;
            pwm      = cyc % (MAXV + 1);
            tick     = ((cyc % STEP) == STEP - 1);
            exp_busy = 1'b0;
            for (int i = 0; i < N; i++) begin
                tgt = bus.led_in[i] ? MAXV : 0;
                if (lvl[i] != tgt) exp_busy = 1'b1;
                if (bus.fade_en) exp_led[i] = (lvl[i] == MAXV) || (pwm < lvl[i]);
                else             exp_led[i] = bus.led_in[i];
                if (!bus.fade_en)          lvl[i] = tgt;
                else if (tick && tgt > lvl[i]) lvl[i] = lvl[i] + 1;
                else if (tick && tgt < lvl[i]) lvl[i] = lvl[i] - 1;
            end
            cyc = cyc + 1;
        end
    end

    bit run_cmp = 1'b1;
    always @(negedge clk) begin
        if (run_cmp) begin
            total = total + 1;
            if (bus.led_out !== exp_led || bus.busy !== exp_busy) begin
                bad = bad + 1;
                $display("FAIL model t=%0t: led_out=%03h busy=%b, expected led_out=%03h busy=%b",
                         $time, bus.led_out, bus.busy, exp_led, exp_busy);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] word, input logic fen);
        reset_n = 1'b0;
        step();
        step();
        bus.led_in  = word;
        bus.fade_en = fen;
        reset_n     = 1'b1;
    endtask

    int cnt;

    initial begin
        bus.led_in  = 9'h1FF;
        bus.fade_en = 1'b1;

        // Reset hold, then full ramp 0 -> 15 in 30 cycles.
        step(); step(); step();
        check("reset_led_out", 32'(bus.led_out), 32'h0);
        check("reset_busy",    32'(bus.busy),    32'h0);
        reset_n = 1'b1;
        for (int c = 0; c < 32; c++) begin
            step();
            if (c + 1 == 1)  check("busy_rise",      32'(bus.busy), 32'h1);
            if (c + 1 == 30) check("busy_last_step", 32'(bus.busy), 32'h1);
            if (c + 1 == 31) begin
                check("busy_fall",     32'(bus.busy),    32'h0);
                check("ramp_full_on",  32'(bus.led_out), 32'h1FF);
            end
            if (c + 1 == 32) check("full_on_at_pwm0", 32'(bus.led_out), 32'h1FF);
        end

        // Duty: reach level 5, then alternate direction so level sits at 4/5.
        do_reset(9'h001, 1'b1);
        cnt = 0;
        for (int c = 0; c < 32; c++) begin
            bus.led_in[0] = (c < 10) ? 1'b1 : ((c % 4) == 1);
            step();
            if (c >= 16) cnt = cnt + int'(bus.led_out[0]);
        end
        check("duty_high_count", 32'(cnt), 32'd4);

        // Reversal at level 6 on channel 3.
        do_reset(9'h008, 1'b1);
        for (int c = 0; c < 30; c++) begin
            bus.led_in = (c < 12) ? 9'h008 : 9'h000;
            step();
            if (c + 1 == 24) check("rev_busy_last", 32'(bus.busy), 32'h1);
            if (c + 1 == 25) check("rev_busy_fall", 32'(bus.busy), 32'h0);
        end

        // Bypass, then re-enable fade with unchanged word.
        bus.fade_en = 1'b0;
        bus.led_in  = 9'h0A5;
        step();
        check("bypass_latency", 32'(bus.led_out), 32'h0A5);
        step();
        bus.fade_en = 1'b1;
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (bus.led_out == 9'h0A5 && bus.busy == 1'b0) cnt = cnt + 1;
        end
        check("reenable_steady", 32'(cnt), 32'd16);

        // Independent channels: 0x100 -> 0x001 in one cycle.
        bus.fade_en = 1'b0;
        bus.led_in  = 9'h100;
        step();
        step();
        bus.fade_en = 1'b1;
        bus.led_in  = 9'h001;
        step();
        check("indep_busy_rise", 32'(bus.busy), 32'h1);
        for (int c = 0; c < 31; c++) step();
        check("indep_done_led",  32'(bus.led_out), 32'h001);
        check("indep_done_busy", 32'(bus.busy),    32'h0);

        // Reset mid-ramp while outputs are high, then ramp restarts from 0.
        do_reset(9'h1FF, 1'b1);
        for (int c = 0; c < 17; c++) step();
        check("midramp_led_before", 32'(bus.led_out), 32'h1FF);
        #1;
        reset_n = 1'b0;
        #1;
        check("midramp_async_led",  32'(bus.led_out), 32'h0);
        check("midramp_async_busy", 32'(bus.busy),    32'h0);
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c + 1 == 1) check("restart_busy",   32'(bus.busy),       32'h1);
            if (c + 1 == 9) check("restart_from_0", 32'(bus.led_out[0]), 32'h0);
        end

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
